// File: rtl/cardinal_link_port.sv
// Router-side endpoint of one NIC link.
// Two virtual channels share the link in alternating cycles. On each cycle the
// link side serves VC ~net_polarity and the core side serves VC net_polarity.
// Each VC has a single-entry buffer in each direction. Because the two sides
// always serve different VCs, no buffer entry is ever written and drained in
// the same cycle.
module cardinal_link_port #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  output logic          net_polarity,
  input  logic          net_so,
  input  logic [DW-1:0] net_do,
  output logic          net_ro,
  output logic          net_si,
  output logic [DW-1:0] net_dl,
  input  logic          net_ri,
  output logic          rtr_out_valid,
  output logic [DW-1:0] rtr_out_data,
  input  logic          rtr_out_ready,
  input  logic          rtr_in_valid,
  input  logic [DW-1:0] rtr_in_data,
  output logic          rtr_in_ready,
  output logic          err_vc,
  output logic [15:0]   rx_count,
  output logic [15:0]   tx_count
);

  logic          pol_q, pol_d;
  logic [1:0]    in_full_q, in_full_d;
  logic [1:0]    eg_full_q, eg_full_d;
  logic [DW-1:0] in_buf_q [2];
  logic [DW-1:0] in_buf_d [2];
  logic [DW-1:0] eg_buf_q [2];
  logic [DW-1:0] eg_buf_d [2];
  logic          err_vc_q, err_vc_d;
  logic [15:0]   rx_count_q, rx_count_d;
  logic [15:0]   tx_count_q, tx_count_d;

  logic          link_vc;
  logic          core_vc;
  logic          nic_offer;
  logic          nic_accept;
  logic          nic_bad_vc;
  logic          egress_write;
  logic          egress_drain;

  // Output decode and next-state computation for both directions.
  always_comb begin
    pol_d        = ~pol_q;
    in_full_d    = in_full_q;
    eg_full_d    = eg_full_q;
    in_buf_d     = in_buf_q;
    eg_buf_d     = eg_buf_q;
    err_vc_d     = err_vc_q;
    rx_count_d   = rx_count_q;
    tx_count_d   = tx_count_q;

    link_vc      = ~pol_q;
    core_vc      = pol_q;

    net_polarity = pol_q;
    net_ro       = ~in_full_q[link_vc];
    net_si       = eg_full_q[link_vc];
    net_dl       = eg_buf_q[link_vc];
    rtr_out_valid = in_full_q[core_vc];
    rtr_out_data  = in_buf_q[core_vc];
    rtr_in_ready  = ~eg_full_q[core_vc] & (rtr_in_data[DW-1] == core_vc);
    err_vc       = err_vc_q;
    rx_count     = rx_count_q;
    tx_count     = tx_count_q;

    nic_offer    = net_so & net_ro;
    nic_accept   = nic_offer & (net_do[DW-1] == link_vc);
    nic_bad_vc   = nic_offer & (net_do[DW-1] == core_vc);
    egress_write = rtr_in_valid & rtr_in_ready;
    egress_drain = net_si & net_ri;

    if (nic_accept) begin
      in_buf_d[link_vc]  = net_do;
      in_full_d[link_vc] = 1'b1;
      if (rx_count_q != 16'hFFFF) begin
        rx_count_d = rx_count_q + 16'd1;
      end
    end

    if (nic_bad_vc) begin
      err_vc_d = 1'b1;
    end

    if (rtr_out_valid && rtr_out_ready) begin
      in_full_d[core_vc] = 1'b0;
    end

    if (egress_write) begin
      eg_buf_d[core_vc]  = rtr_in_data;
      eg_full_d[core_vc] = 1'b1;
    end

    if (egress_drain) begin
      eg_full_d[link_vc] = 1'b0;
      if (tx_count_q != 16'hFFFF) begin
        tx_count_d = tx_count_q + 16'd1;
      end
    end
  end

  // Control state: polarity, full bits, error flag and counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pol_q      <= 1'b0;
      in_full_q  <= 2'b00;
      eg_full_q  <= 2'b00;
      err_vc_q   <= 1'b0;
      rx_count_q <= 16'd0;
      tx_count_q <= 16'd0;
    end else begin
      pol_q      <= pol_d;
      in_full_q  <= in_full_d;
      eg_full_q  <= eg_full_d;
      err_vc_q   <= err_vc_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Packet storage; contents are meaningless unless the matching full bit is set.
  always_ff @(posedge clk) begin
    in_buf_q <= in_buf_d;
    eg_buf_q <= eg_buf_d;
  end

endmodule

// File: tb/tb_cardinal_link_port.sv
// Self-checking bench for cardinal_link_port. A behavioural model tracks
// per-VC buffer occupancy, counters and the error flag. The model's link/core
// VC selection comes from the parity of the cycles since reset.
module tb_cardinal_link_port;

  logic        clk;
  logic        reset;
  logic        net_polarity;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ro;
  logic        net_si;
  logic [63:0] net_dl;
  logic        net_ri;
  logic        rtr_out_valid;
  logic [63:0] rtr_out_data;
  logic        rtr_out_ready;
  logic        rtr_in_valid;
  logic [63:0] rtr_in_data;
  logic        rtr_in_ready;
  logic        err_vc;
  logic [15:0] rx_count;
  logic [15:0] tx_count;

  int check_count = 0;
  int error_count = 0;

  // Behavioural model state.
  bit          m_known = 0;
  int          m_pol;
  bit          m_in_full [2];
  logic [63:0] m_in_buf  [2];
  bit          m_eg_full [2];
  logic [63:0] m_eg_buf  [2];
  bit          m_err;
  int          m_rx;
  int          m_tx;

  cardinal_link_port #(.DW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .net_polarity  (net_polarity),
    .net_so        (net_so),
    .net_do        (net_do),
    .net_ro        (net_ro),
    .net_si        (net_si),
    .net_dl        (net_dl),
    .net_ri        (net_ri),
    .rtr_out_valid (rtr_out_valid),
    .rtr_out_data  (rtr_out_data),
    .rtr_out_ready (rtr_out_ready),
    .rtr_in_valid  (rtr_in_valid),
    .rtr_in_data   (rtr_in_data),
    .rtr_in_ready  (rtr_in_ready),
    .err_vc        (err_vc),
    .rx_count      (rx_count),
    .tx_count      (tx_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge and check outputs against the model.
  // Then advance the model across the rising edge.
  task automatic applyStimulus(input bit rst_n, input bit so, input logic [63:0] d_o,
                               input bit out_rdy, input bit in_val, input logic [63:0] in_d,
                               input bit ri, input bit do_check);
    int lnk;
    int core;
    bit exp_ready;
    @(negedge clk);
    reset         = rst_n;
    net_so        = so;
    net_do        = d_o;
    rtr_out_ready = out_rdy;
    rtr_in_valid  = in_val;
    rtr_in_data   = in_d;
    net_ri        = ri;
    #1;
    lnk       = 1 - m_pol;
    core      = m_pol;
    exp_ready = !m_eg_full[core] && (int'(in_d[63]) == core);
    if (m_known && do_check) begin
      checkOutput("net_polarity", 64'(net_polarity), 64'(m_pol));
      checkOutput("net_ro", 64'(net_ro), 64'(!m_in_full[lnk]));
      checkOutput("rtr_out_valid", 64'(rtr_out_valid), 64'(m_in_full[core]));
      if (m_in_full[core]) checkOutput("rtr_out_data", rtr_out_data, m_in_buf[core]);
      checkOutput("rtr_in_ready", 64'(rtr_in_ready), 64'(exp_ready));
      checkOutput("net_si", 64'(net_si), 64'(m_eg_full[lnk]));
      if (m_eg_full[lnk]) checkOutput("net_dl", net_dl, m_eg_buf[lnk]);
      checkOutput("err_vc", 64'(err_vc), 64'(m_err));
      checkOutput("rx_count", 64'(rx_count), 64'(m_rx));
      checkOutput("tx_count", 64'(tx_count), 64'(m_tx));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1;
      m_pol = 0;
      m_in_full[0] = 0; m_in_full[1] = 0;
      m_eg_full[0] = 0; m_eg_full[1] = 0;
      m_err = 0; m_rx = 0; m_tx = 0;
    end else if (m_known) begin
      if (so && !m_in_full[lnk]) begin
        if (int'(d_o[63]) == lnk) begin
          m_in_full[lnk] = 1;
          m_in_buf[lnk]  = d_o;
          if (m_rx < 65535) m_rx++;
        end else begin
          m_err = 1;
        end
      end
      if (m_in_full[core] && out_rdy) m_in_full[core] = 0;
      if (in_val && exp_ready) begin
        m_eg_full[core] = 1;
        m_eg_buf[core]  = in_d;
      end
      if (m_eg_full[lnk] && ri) begin
        m_eg_full[lnk] = 0;
        if (m_tx < 65535) m_tx++;
      end
      m_pol = 1 - m_pol;
    end
    #1;
  endtask

  task automatic idleCycle(input bit out_rdy, input bit ri);
    applyStimulus(1, 0, 64'd0, out_rdy, 0, 64'd0, ri, 1);
  endtask

  // Idle until the next driven cycle will see the requested polarity (at most two cycles).
  task automatic alignPolarity(input int target);
    for (int i = 0; i < 2 && m_pol != target; i++) idleCycle(0, 0);
    checkOutput("align_polarity", 64'(net_polarity), 64'(target));
  endtask

  // Directed scenarios, saturation run, then randomized traffic with occasional resets.
  initial begin
    logic [63:0] rnd;
    reset = 1'b0; net_so = 0; net_do = '0; net_ri = 0;
    rtr_out_ready = 0; rtr_in_valid = 0; rtr_in_data = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'd0, 0, 0, 64'd0, 0, 1);
    checkOutput("reset_pol", 64'(net_polarity), 64'd0);
    checkOutput("reset_net_ro", 64'(net_ro), 64'd1);
    checkOutput("reset_net_si", 64'(net_si), 64'd0);
    checkOutput("reset_out_valid", 64'(rtr_out_valid), 64'd0);
    checkOutput("reset_rx", 64'(rx_count), 64'd0);

    // Ingress of one VC1 packet and its drain by the core.
    alignPolarity(0);
    applyStimulus(1, 1, 64'h8000_0000_0000_0001, 0, 0, 64'd0, 0, 1);
    checkOutput("ing_valid", 64'(rtr_out_valid), 64'd1);
    checkOutput("ing_data", rtr_out_data, 64'h8000_0000_0000_0001);
    checkOutput("ing_rx", 64'(rx_count), 64'd1);
    idleCycle(1, 0);
    idleCycle(0, 0);
    checkOutput("ing_drained", 64'(rtr_out_valid), 64'd0);

    // Ingress backpressure: VC1 slot stays full and refuses a second packet.
    alignPolarity(0);
    applyStimulus(1, 1, 64'h8000_0000_0000_00AA, 0, 0, 64'd0, 0, 1);
    idleCycle(0, 0);
    checkOutput("bp_ro_0", 64'(net_ro), 64'd0);
    applyStimulus(1, 1, 64'h8000_0000_0000_00BB, 0, 0, 64'd0, 0, 1);
    idleCycle(0, 0);
    checkOutput("bp_ro_1", 64'(net_ro), 64'd0);
    checkOutput("bp_rx", 64'(rx_count), 64'd2);
    idleCycle(0, 0);
    idleCycle(1, 0);
    checkOutput("bp_ro_after", 64'(net_ro), 64'd1);

    // VC mismatch sets the sticky error flag and writes nothing.
    alignPolarity(0);
    applyStimulus(1, 1, 64'h0000_0000_0000_0033, 0, 0, 64'd0, 0, 1);
    checkOutput("vc_err_set", 64'(err_vc), 64'd1);
    checkOutput("vc_err_rx", 64'(rx_count), 64'd2);
    for (int i = 0; i < 4; i++) idleCycle(1, 0);
    checkOutput("vc_err_sticky", 64'(err_vc), 64'd1);

    // Egress of one VC1 packet held by NIC backpressure, then delivered.
    alignPolarity(1);
    applyStimulus(1, 0, 64'd0, 0, 1, 64'h8000_0000_0000_0002, 0, 1);
    checkOutput("eg_si", 64'(net_si), 64'd1);
    checkOutput("eg_dl", net_dl, 64'h8000_0000_0000_0002);
    for (int i = 0; i < 4; i++) idleCycle(0, 0);
    checkOutput("eg_held", 64'(net_si), 64'd1);
    idleCycle(0, 1);
    checkOutput("eg_tx", 64'(tx_count), 64'd1);

    // Saturation: one matching packet per cycle, drained every cycle by the core.
    for (int i = 0; i < 65540; i++) begin
      rnd = {$urandom, $urandom};
      rnd[63] = (m_pol == 0);
      applyStimulus(1, 1, rnd, 1, 0, 64'd0, 0, (i % 4096) == 0);
    end
    checkOutput("sat_rx", 64'(rx_count), 64'hFFFF);

    // Fill both egress buffers, then reset discards everything.
    alignPolarity(0);
    applyStimulus(1, 0, 64'd0, 1, 1, 64'h0000_0000_0000_1234, 0, 1);
    applyStimulus(1, 0, 64'd0, 1, 1, 64'h8000_0000_0000_5678, 0, 1);
    checkOutput("full_si", 64'(net_si), 64'd1);
    applyStimulus(0, 0, 64'd0, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
    checkOutput("rst_si", 64'(net_si), 64'd0);
    checkOutput("rst_rx", 64'(rx_count), 64'd0);
    checkOutput("rst_tx", 64'(tx_count), 64'd0);
    checkOutput("rst_pol", 64'(net_polarity), 64'd0);
    checkOutput("rst_in_ready", 64'(rtr_in_ready), 64'd0);

    // Randomized traffic in both directions with rare resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, 1'($urandom), {$urandom, $urandom},
                    1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/cardinal_link_port.md
CARDINAL_LINK_PORT -- requirements
Module: cardinal_link_port

Router-side endpoint of one NIC link. It receives packets the NIC sends (net_so/net_do) and sends packets to the NIC (net_si/net_dl). It uses two virtual channels (VC0 even, VC1 odd) and keeps one single-entry buffer per VC in each direction.

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- net_polarity  output  1  link polarity; toggles every cycle.
- net_so  input  1  NIC send strobe.
- net_do  input  64  NIC packet; bit 63 = VC.
- net_ro  output  1  port ready to accept a NIC packet.
- net_si  output  1  port send strobe to the NIC.
- net_dl  output  64  packet to the NIC.
- net_ri  input  1  NIC ready to accept.
- rtr_out_valid  output  1  ingress packet offered to the router core.
- rtr_out_data  output  64  ingress packet.
- rtr_out_ready  input  1  core accepts the ingress packet.
- rtr_in_valid  input  1  core offers an egress packet.
- rtr_in_data  input  64  egress packet; bit 63 = VC.
- rtr_in_ready  output  1  port accepts the egress packet.
- err_vc  output  1  sticky VC-mismatch flag.
- rx_count  output  16  saturating count of packets accepted from the NIC.
- tx_count  output  16  saturating count of packets delivered to the NIC.

REQ-002 The block SHALL use the parameter DW, default 64, as the packet width; the VC SHALL always be bit DW-1.

Function
REQ-003 The polarity register SHALL load 0 at reset, then invert on every clock edge.
REQ-004 Link-side transfers (net_*) SHALL carry only the VC equal to ~net_polarity; core-side transfers (rtr_*) SHALL carry only the VC equal to net_polarity.
REQ-005 Each ingress buffer and each egress buffer SHALL hold one packet plus a full bit.
REQ-006 net_ro SHALL be combinational: net_ro = ~in_full[~net_polarity].
REQ-007 The NIC ingress transfer SHALL follow these rules:
- Condition: net_so & net_ro & (net_do[63] == ~net_polarity).
- Action: write net_do into in_buf[~net_polarity] and set its full bit at the same edge.
REQ-008 If net_so & net_ro and net_do[63] == net_polarity:
- No buffer SHALL be written.
- err_vc SHALL set at the next edge and stay set until reset.
REQ-009 rtr_out_valid SHALL equal in_full[net_polarity], and rtr_out_data SHALL equal in_buf[net_polarity].
- When rtr_out_valid & rtr_out_ready, that full bit SHALL clear at the edge.
REQ-010 rtr_in_ready SHALL equal ~eg_full[net_polarity] & (rtr_in_data[63] == net_polarity).
- When rtr_in_valid & rtr_in_ready, rtr_in_data SHALL be written into eg_buf[net_polarity] and its full bit set.
REQ-011 net_si SHALL equal eg_full[~net_polarity], and net_dl SHALL equal eg_buf[~net_polarity].
- When net_si & net_ri, that full bit SHALL clear at the edge.
REQ-012 The buffer written and the buffer drained in any one direction SHALL differ in every cycle, so no same-cycle write/read conflict on one entry SHALL exist.
REQ-013 A full buffer SHALL hold its data unchanged until it drains, regardless of how many polarity periods pass.
REQ-014 rx_count SHALL increment on each REQ-007 transfer.
REQ-015 tx_count SHALL increment on each REQ-011 transfer.
REQ-016 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-017 All outputs SHALL be functions of registered state, net_polarity, rtr_in_data, and (for REQ-008) net_so/net_do only; there SHALL be no combinational path from net_ri or rtr_out_ready to any output.

Reset
REQ-018 While reset = 0 at a rising edge, the following SHALL be cleared: all four full bits, err_vc, rx_count, tx_count and net_polarity.
- Buffer data SHALL be don't-care.
REQ-019 During and immediately after reset, the outputs SHALL be: net_ro = 1, net_si = 0, rtr_out_valid = 0, and rtr_in_ready = (rtr_in_data[63] == 0).
REQ-020 Reset asserted mid-transfer SHALL discard all buffered packets.
- No transfer SHALL complete at an edge where reset = 0.

Verification
REQ-021 Ingress: release reset; on the cycle with net_polarity = 0, drive net_so = 1, net_do = 64'h8000_0000_0000_0001 -> in_full[1] sets and rx_count = 1. On the next cycle rtr_out_valid = 1 with the same data; with rtr_out_ready = 1 it clears after one edge.
REQ-022 Ingress backpressure: hold rtr_out_ready = 0 and send one VC1 packet -> net_ro = 0 on every polarity-0 cycle. A second VC1 packet is not accepted, and rx_count stays 1 until the core drains.
REQ-023 VC mismatch: send net_do[63] = 0 while net_polarity = 0 -> no buffer written, rx_count unchanged, err_vc = 1 and stays set until reset.
REQ-024 Egress: with net_polarity = 1, drive rtr_in_valid = 1, rtr_in_data = 64'h8000_0000_0000_0002 -> accepted. On the next cycle net_si = 1 and net_dl = 64'h8000_0000_0000_0002; with net_ri = 0 it is held across 4 cycles. Raising net_ri then gives tx_count = 1.
REQ-025 Saturation and reset: force 65536 ingress packets -> rx_count stays 16'hFFFF. Then assert reset with both egress buffers full -> net_si = 0, all counters 0 and net_polarity = 0 after one edge.
